// File: rtl/time_set_ctrl.sv
// Button front end for the clock's set/display path: debounces three buttons,
// toggles 12/24-hour mode and walks the hour/minute/second edit fields.
module time_set_ctrl #(
    parameter int unsigned DB_CYCLES      = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
    parameter int unsigned REPEAT_DELAY   = 50_000_000,
    parameter int unsigned REPEAT_PERIOD  = 20_000_000,
    parameter int unsigned BLINK_HALF     = 25_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    output logic       hour_mode,
    output logic [1:0] state,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blink
);

    // state    | meaning
    // RUN      | normal timekeeping, mode button toggles 12/24-hour display
    // SET_HOUR | editing hours, inc pulses inc_hour (auto-repeat)
    // SET_MIN  | editing minutes, inc pulses inc_min (auto-repeat)
    // SET_SEC  | editing seconds, inc pulses clr_sec (no repeat)
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam int BL_W  = $clog2(BLINK_HALF + 1);

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);
    localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_HALF - 1);

    localparam int BI_MODE = 0;
    localparam int BI_SET  = 1;
    localparam int BI_INC  = 2;

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      db;
    logic [2:0]      db_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    state_t cur_state;
    state_t next_state;

    logic            ev_set;
    logic            ev_inc;
    logic            ev_mode;
    logic            to_hit;
    logic            timeout;
    logic [TO_W-1:0] to_cnt;

    logic             rpt_zone;
    logic             rpt_armed;
    logic             rpt_phase;
    logic             rpt_ev;
    logic [RPT_W-1:0] rpt_cnt;

    logic            inc_hour_d;
    logic            inc_min_d;
    logic            clr_sec_d;
    logic            mode_tgl;
    logic            strobe_any;
    logic [BL_W-1:0] bl_cnt;

    assign raw = {btn_inc, btn_set, btn_mode};

    // Synchronize, require DB_CYCLES of stable mismatch, then register the rising edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            press <= db & ~db_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rpt_zone = ((cur_state == SET_HOUR) || (cur_state == SET_MIN)) && db[BI_INC];
    assign rpt_ev   = rpt_armed && rpt_zone && (rpt_phase ? (rpt_cnt == RPT_PER) : (rpt_cnt == RPT_DLY));

    // set beats inc beats mode; a pending timeout yields to any accepted event
    assign ev_set  = press[BI_SET];
    assign ev_inc  = !press[BI_SET] && (press[BI_INC] || rpt_ev);
    assign ev_mode = !press[BI_SET] && !press[BI_INC] && !rpt_ev && press[BI_MODE];
    assign to_hit  = (cur_state != RUN) && (to_cnt == TO_LAST);
    assign timeout = to_hit && !ev_set && !ev_inc;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) cur_state <= RUN;
        else     cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            RUN: begin
                if (ev_set) next_state = SET_HOUR;
            end
            SET_HOUR: begin
                if (ev_set)       next_state = SET_MIN;
                else if (timeout) next_state = RUN;
            end
            SET_MIN: begin
                if (ev_set)       next_state = SET_SEC;
                else if (timeout) next_state = RUN;
            end
            SET_SEC: begin
                if (ev_set || timeout) next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;
        clr_sec_d  = 1'b0;
        mode_tgl   = 1'b0;
        case (cur_state)
            RUN:      mode_tgl   = ev_mode;
            SET_HOUR: inc_hour_d = ev_inc;
            SET_MIN:  inc_min_d  = ev_inc;
            SET_SEC:  clr_sec_d  = ev_inc;
            default:  mode_tgl   = 1'b0;
        endcase
    end

    assign strobe_any = inc_hour_d | inc_min_d | clr_sec_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hour_mode <= 1'b0;
            inc_hour  <= 1'b0;
            inc_min   <= 1'b0;
            clr_sec   <= 1'b0;
        end else begin
            hour_mode <= hour_mode ^ mode_tgl;
            inc_hour  <= inc_hour_d;
            inc_min   <= inc_min_d;
            clr_sec   <= clr_sec_d;
        end
    end

    // Idle timer only runs while editing; every accepted edit or field change restarts it
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            to_cnt <= '0;
        end else if ((next_state == RUN) || ev_set || ev_inc) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Repeat is armed only by a fresh press inside an hour/minute field
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rpt_armed <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
        end else if (!rpt_zone || ev_set || timeout) begin
            rpt_armed <= 1'b0;
            rpt_phase <= 1'b0;
            rpt_cnt   <= '0;
        end else if (press[BI_INC]) begin
            rpt_armed <= 1'b1;
            rpt_phase <= 1'b0;
            rpt_cnt   <= RPT_W'(1);
        end else if (rpt_ev) begin
            rpt_phase <= 1'b1;
            rpt_cnt   <= RPT_W'(1);
        end else if (rpt_armed) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            blink  <= 1'b1;
            bl_cnt <= '0;
        end else if ((next_state == RUN) || (next_state != cur_state) || strobe_any) begin
            blink  <= 1'b1;
            bl_cnt <= '0;
        end else if (bl_cnt == BL_LAST) begin
            blink  <= ~blink;
            bl_cnt <= '0;
        end else begin
            bl_cnt <= bl_cnt + 1'b1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/timeout/repeat/blink constants.
module tb_time_set_ctrl;

    logic       Clk;
    logic       Rst;
    logic       btn_mode;
    logic       btn_set;
    logic       btn_inc;
    logic       hour_mode;
    logic [1:0] state;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic       blink;

    int checks = 0;
    int errors = 0;
    int n_hour = 0;
    int n_min  = 0;
    int n_sec  = 0;
    int n_multi = 0;

    int base_hour;
    int base_min;
    int base_sec;

    time_set_ctrl #(
        .DB_CYCLES     (4),
        .TIMEOUT_CYCLES(100),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5),
        .BLINK_HALF    (8)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .btn_mode (btn_mode),
        .btn_set  (btn_set),
        .btn_inc  (btn_inc),
        .hour_mode(hour_mode),
        .state    (state),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .clr_sec  (clr_sec),
        .blink    (blink)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Strobe high-cycle counters; a stretched strobe shows up as an extra count
    always @(negedge Clk) begin
        if (!Rst) begin
            if (inc_hour === 1'b1) n_hour++;
            if (inc_min  === 1'b1) n_min++;
            if (clr_sec  === 1'b1) n_sec++;
            if ((int'(inc_hour) + int'(inc_min) + int'(clr_sec)) > 1) n_multi++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic val);
        case (which)
            0: btn_mode = val;
            1: btn_set  = val;
            default: btn_inc = val;
        endcase
    endtask

    task automatic press_btn(input int which, input int hold);
        drive(which, 1'b1);
        repeat (hold) tick();
        drive(which, 1'b0);
        repeat (12) tick();
    endtask

    function automatic logic rpt_expect(input int k);
        return (k == 8) || ((k >= 28) && (k <= 53) && (((k - 28) % 5) == 0));
    endfunction

    initial begin
        Rst = 1'b1;
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) tick();
        check("rst_hour_mode", hour_mode, 0);
        check("rst_state", state, 0);
        check("rst_strobes", {inc_hour, inc_min, clr_sec}, 0);
        check("rst_blink", blink, 1);
        Rst = 1'b0;
        repeat (2) tick();
        check("run_state", state, 0);
        check("run_blink", blink, 1);

        // Mode press: hour_mode flips on the 8th edge after the raw edge
        btn_mode = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("mode1_k%0d", k), hour_mode, (k >= 8) ? 1 : 0);
        end
        btn_mode = 1'b0;
        repeat (12) tick();
        check("mode1_hold", hour_mode, 1);
        check("mode1_state", state, 0);
        btn_mode = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("mode2_k%0d", k), hour_mode, (k >= 8) ? 0 : 1);
        end
        btn_mode = 1'b0;
        repeat (12) tick();

        // Set glitches of 3 cycles must be rejected
        for (int g = 0; g < 3; g++) begin
            btn_set = 1'b1;
            repeat (3) tick();
            btn_set = 1'b0;
            repeat (3) tick();
        end
        repeat (10) tick();
        check("glitch_state", state, 0);

        press_btn(1, 8);
        check("set1_state", state, 1);
        press_btn(1, 8);
        check("set2_state", state, 2);
        press_btn(1, 8);
        check("set3_state", state, 3);
        press_btn(1, 8);
        check("set4_state", state, 0);
        check("set_no_strobes", n_hour + n_min + n_sec, 0);

        // SET_HOUR: two inc presses, then set+inc together
        press_btn(1, 8);
        check("hour_state", state, 1);
        press_btn(2, 8);
        press_btn(2, 8);
        check("inc_hour_count", n_hour, 2);
        btn_set = 1'b1;
        btn_inc = 1'b1;
        repeat (8) tick();
        btn_set = 1'b0;
        btn_inc = 1'b0;
        repeat (12) tick();
        check("setinc_state", state, 2);
        check("setinc_no_min", n_min, 0);
        check("setinc_hour", n_hour, 2);

        // SET_MIN: held inc auto-repeats after 20 then every 5 cycles
        btn_inc = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 50) btn_inc = 1'b0;
            check($sformatf("rpt_k%0d", k), inc_min, rpt_expect(k));
        end
        check("rpt_count", n_min, 7);
        check("rpt_state", state, 2);

        // SET_SEC: held inc gives a single clr_sec
        press_btn(1, 8);
        check("sec_state", state, 3);
        base_sec = n_sec;
        press_btn(2, 50);
        check("clr_sec_count", n_sec - base_sec, 1);
        check("sec_state_after", state, 3);
        press_btn(1, 8);
        check("sec_to_run", state, 0);

        // Idle timeout from SET_HOUR with blink waveform
        base_hour = n_hour;
        base_min  = n_min;
        btn_set = 1'b1;
        for (int k = 1; k <= 115; k++) begin
            tick();
            if (k == 10) btn_set = 1'b0;
            check($sformatf("to_state_k%0d", k), state, ((k >= 8) && (k < 108)) ? 1 : 0);
            check($sformatf("to_blink_k%0d", k), blink,
                  ((k >= 8) && (k < 108)) ? ((((k - 8) / 8) % 2 == 0) ? 1 : 0) : 1);
        end
        check("to_no_strobe", (n_hour - base_hour) + (n_min - base_min), 0);

        // Asynchronous reset while editing minutes with the field blanked
        press_btn(0, 8);
        check("pre_rst_mode", hour_mode, 1);
        press_btn(1, 8);
        press_btn(1, 8);
        check("pre_rst_state", state, 2);
        check("pre_rst_blink", blink, 0);
        #2;
        Rst = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_blink", blink, 1);
        check("async_mode", hour_mode, 0);
        tick();
        Rst = 1'b0;
        tick();
        btn_mode = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("post_rst_k%0d", k), hour_mode, (k >= 8) ? 1 : 0);
        end
        btn_mode = 1'b0;
        repeat (12) tick();

        check("strobe_exclusive", n_multi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven controller for the digital clock's set/display path. It debounces three raw push-buttons, toggles 24/12-hour display mode, and sequences the hour → minute → second edit fields. It also issues single-cycle increment/clear strobes to the timekeeping counters and drives the blink enable for the field being edited. It sits between the board buttons and the timekeeper/display blocks, and replaces the free-running divided-clock toggling of the mode bit with a single-clock, reset-defined design.

## Interface
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 1_000_000_000: idle cycles in any set state before automatic return to RUN.
- REPEAT_DELAY, 50_000_000: cycles btn_inc must be held before auto-repeat starts.
- REPEAT_PERIOD, 20_000_000: cycles between auto-repeat strobes.
- BLINK_HALF, 25_000_000: cycles per blink half-period.
- Clk, input, 1: system clock; all logic on its rising edge.
- Rst, input, 1: asynchronous, active-high reset.
- btn_mode, input, 1: raw 24/12-hour toggle button, asynchronous, active-high.
- btn_set, input, 1: raw field-advance button, asynchronous, active-high.
- btn_inc, input, 1: raw increment button, asynchronous, active-high.
- hour_mode, output, 1: 0 = 24-hour, 1 = 12-hour.
- state, output, 2: 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
- inc_hour, output, 1: one-cycle increment strobe to the hour counter.
- inc_min, output, 1: one-cycle increment strobe to the minute counter.
- clr_sec, output, 1: one-cycle strobe that zeroes the seconds counter.
- blink, output, 1: 1 = edited field visible, 0 = blanked; constant 1 in RUN.

## Operation
- Reset values: hour_mode=0, state=RUN, inc_hour=inc_min=clr_sec=0, blink=1. Debounced levels, counters and synchronizers are all cleared.
- Per button, in this order:
  - 2-FF synchronizer.
  - Counter runs while the synchronized level differs from the debounced level. When the counter reaches DB_CYCLES the debounced level flips; any mismatch gap clears the counter.
  - Press event: one-cycle pulse on a 0→1 debounced transition.
- Event priority in the same cycle: set > inc > mode. Lower-priority events in that cycle are discarded.
- State transitions:
  - RUN: set → SET_HOUR; mode → hour_mode toggles; inc ignored.
  - SET_HOUR: set → SET_MIN; inc → inc_hour.
  - SET_MIN: set → SET_SEC; inc → inc_min.
  - SET_SEC: set → RUN; inc → clr_sec.
  - mode is ignored in all set states.
- Timeout counter:
  - Cleared on every accepted event and on entry to any set state.
  - In a set state it increments each cycle. When it reaches TIMEOUT_CYCLES, state returns to RUN and no strobe is issued.
- Auto-repeat:
  - Applies in SET_HOUR and SET_MIN while btn_inc stays debounced-high.
  - After REPEAT_DELAY cycles from the press event, the block generates a repeat event every REPEAT_PERIOD cycles.
  - Repeat events count as accepted events and reset the timeout counter.
  - No repeat in SET_SEC or RUN. Release or a state change cancels repeat.
- Blink:
  - On entry to any set state (including SET_MIN→SET_SEC), blink=1 and the blink counter clears.
  - blink toggles every BLINK_HALF cycles.
  - Any inc strobe forces blink=1 and restarts the counter.

## Timing
- Raw input held steady → debounced level changes DB_CYCLES+2 cycles after the raw edge. The press event follows 1 cycle later, and registered outputs (state, hour_mode, strobes) update 1 cycle after that: total DB_CYCLES+4 cycles.
- Strobes are exactly one cycle wide; at most one of inc_hour/inc_min/clr_sec is high in any cycle.
- Bounce shorter than DB_CYCLES produces no event. A press and its release each require DB_CYCLES of stability.
- Rst asserted mid-operation (e.g. in SET_MIN or during a strobe) returns all outputs to reset values immediately, without waiting for Clk. The first event after deassertion requires a full debounce.
- A timeout and a set event in the same cycle: the set event wins (normal advance), and the timeout counter clears.

## Test plan
- Parameters for all scenarios: DB_CYCLES=4, TIMEOUT_CYCLES=100, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_HALF=8.
- Reset, then clean btn_mode press → hour_mode goes 0→1 exactly 8 cycles after the raw edge; a second press → 0.
- Pulse btn_set with 3-cycle glitches → no change. Then 4 clean presses → state 01, 10, 11, 00 in sequence with no strobes.
- In SET_HOUR, press btn_inc twice → two single-cycle inc_hour pulses. Then press btn_set and btn_inc simultaneously → state 10, no inc_min.
- In SET_MIN, hold btn_inc 50 cycles → inc_min at press event, then at +20, +25, +30, …; release stops repeats. In SET_SEC, held inc → exactly one clr_sec.
- Enter SET_HOUR and idle → state returns to 00 after 100 cycles, and blink reads 1,0,1… toggling every 8 cycles before that. Assert Rst while in SET_MIN → state=00, blink=1 without a Clk edge.
